// File: rtl/fifo_rd_serializer_256to16.sv
// fifo_rd_serializer_256to16
// Drains wide words from a prefetch FIFO and emits them one OUT_W lane at a
// time as a bubble-free pixel stream. It also tracks the pixel position in
// the line so that downstream timing logic gets start-of-line and end-of-line
// flags.
module fifo_rd_serializer_256to16 #(
  parameter int IN_W      = 256,
  parameter int OUT_W     = 16,
  parameter int LINE_PIX  = 1920,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [IN_W-1:0]  s_data,
  input  logic             s_vld,
  output logic             s_rdy,
  output logic [OUT_W-1:0] m_data,
  output logic             m_vld,
  input  logic             m_rdy,
  output logic             m_sol,
  output logic             m_eol
);

  localparam int RATIO  = IN_W / OUT_W;
  localparam int LANE_W = $clog2(RATIO);
  localparam int PIX_W  = $clog2(LINE_PIX);

  localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(RATIO - 1);
  localparam logic [PIX_W-1:0]  PIX_LAST  = PIX_W'(LINE_PIX - 1);

  typedef enum logic [0:0] {
    S_EMPTY = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [IN_W-1:0]     hold_q, hold_d;
  logic [LANE_W-1:0]   lane_q, lane_d;
  logic [PIX_W-1:0]    pix_q, pix_d;

  logic                accept;
  logic                load;
  logic [LANE_W-1:0]   lane_sel;
  logic [OUT_W-1:0]    lane_data;

  // Handshakes: a pixel leaves on m_vld&m_rdy; a word is taken only when the
  // current one is fully drained (or nothing is held), and never during
  // reset or flush.
  always_comb begin
    accept = (state_q == S_SHIFT) && m_rdy && !rst && !flush;
    s_rdy  = !rst && !flush &&
             ((state_q == S_EMPTY) || ((lane_q == LANE_LAST) && m_rdy));
    load   = s_rdy && s_vld;
  end

  // Lane select: with MSB_FIRST the lane index is mirrored (RATIO is a
  // power of two, so the mirror is a bitwise inversion).
  always_comb begin
    lane_sel  = MSB_FIRST ? ~lane_q : lane_q;
    lane_data = '0;
    for (int i = 0; i < RATIO; i++) begin
      if (lane_sel == LANE_W'(i)) begin
        lane_data = hold_q[i*OUT_W +: OUT_W];
      end
    end
  end

  // Outputs are forced quiet while reset is asserted; otherwise they follow
  // the registered state, so they hold steady across any stall.
  always_comb begin
    m_vld  = !rst && (state_q == S_SHIFT);
    m_data = rst ? '0 : lane_data;
    m_sol  = m_vld && (pix_q == '0);
    m_eol  = m_vld && (pix_q == PIX_LAST);
  end

  // Next-state: reset and flush win over accept/load; otherwise advance the
  // lane on each accepted beat and reload seamlessly after the last lane.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    lane_d  = lane_q;
    pix_d   = pix_q;
    if (rst) begin
      state_d = S_EMPTY;
      hold_d  = '0;
      lane_d  = '0;
      pix_d   = '0;
    end else if (flush) begin
      state_d = S_EMPTY;
      lane_d  = '0;
      pix_d   = '0;
    end else begin
      if (accept) begin
        pix_d = (pix_q == PIX_LAST) ? '0 : pix_q + PIX_W'(1);
        if (lane_q != LANE_LAST) begin
          lane_d = lane_q + LANE_W'(1);
        end else begin
          lane_d  = '0;
          state_d = S_EMPTY;
        end
      end
      if (load) begin
        hold_d  = s_data;
        lane_d  = '0;
        state_d = S_SHIFT;
      end
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    state_q <= state_d;
    hold_q  <= hold_d;
    lane_q  <= lane_d;
    pix_q   <= pix_d;
  end

endmodule

// File: tb/tb_fifo_rd_serializer_256to16.sv
// Randomized bench for fifo_rd_serializer_256to16. A scoreboard queue holds
// the pixels each accepted word should produce; a monitor on the falling
// edge compares the DUT outputs against the queue head and line position.
module tb_fifo_rd_serializer_256to16;

  localparam int IN_W     = 256;
  localparam int OUT_W    = 16;
  localparam int LINE_PIX = 1920;
  localparam int RATIO    = IN_W / OUT_W;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic [IN_W-1:0]  s_data;
  logic             s_vld;
  logic             s_rdy;
  logic [OUT_W-1:0] m_data;
  logic             m_vld;
  logic             m_rdy;
  logic             m_sol;
  logic             m_eol;

  int checks   = 0;
  int failures = 0;

  logic [OUT_W-1:0] exp_q[$];
  int               beat     = 0;
  bit               acc_last = 1'b0;
  bit               was_rst  = 1'b0;

  always #5 clk = ~clk;

  fifo_rd_serializer_256to16 #(
    .IN_W(IN_W), .OUT_W(OUT_W), .LINE_PIX(LINE_PIX), .MSB_FIRST(1'b0)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .s_data(s_data), .s_vld(s_vld), .s_rdy(s_rdy),
    .m_data(m_data), .m_vld(m_vld), .m_rdy(m_rdy),
    .m_sol(m_sol), .m_eol(m_eol)
  );

  task automatic chk(input string name, input logic [IN_W-1:0] act,
                     input logic [IN_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [IN_W-1:0] rand_word();
    logic [IN_W-1:0] w;
    for (int i = 0; i < IN_W / 32; i++) w[i*32 +: 32] = $urandom();
    return w;
  endfunction

  // Monitor / scoreboard, sampled mid-cycle when all inputs are settled.
  always @(negedge clk) begin
    bit exp_rdy;
    if (rst) begin
      chk("rst_outputs", {m_vld, m_sol, m_eol, s_rdy, m_data}, '0);
      exp_q.delete();
      beat = 0;
    end else begin
      if (was_rst) chk("post_rst_data", m_data, '0);
      // A word may be taken when nothing is pending, or when the only
      // pending pixel is leaving this cycle.
      exp_rdy = !flush && (exp_q.size() == 0 || (exp_q.size() == 1 && m_rdy));
      chk("s_rdy", s_rdy, exp_rdy);
      chk("m_vld", m_vld, exp_q.size() != 0);
      if (m_vld && exp_q.size() != 0) begin
        chk("m_data", m_data, exp_q[0]);
        chk("m_sol", m_sol, (beat % LINE_PIX) == 0);
        chk("m_eol", m_eol, (beat % LINE_PIX) == LINE_PIX - 1);
      end
      if (flush) begin
        exp_q.delete();
        beat = 0;
      end else begin
        if (m_vld && m_rdy && exp_q.size() != 0) begin
          void'(exp_q.pop_front());
          beat++;
        end
        if (s_vld && s_rdy) begin
          for (int k = 0; k < RATIO; k++) exp_q.push_back(OUT_W'(s_data >> (OUT_W * k)));
        end
      end
    end
    acc_last = s_vld && s_rdy;
    was_rst  = rst;
  end

  // Run n cycles: pv/pr are percent chances of s_vld/m_rdy, pf is 1/pf flush
  // chance (0 = never). Unconsumed words are held stable.
  task automatic run(input int n, input int pv, input int pr, input int pf);
    for (int c = 0; c < n; c++) begin
      @(posedge clk); #1;
      if (acc_last || !s_vld) begin
        s_data = rand_word();
        s_vld  = ($urandom_range(99) < pv);
      end
      m_rdy = ($urandom_range(99) < pr);
      flush = (pf != 0) && ($urandom_range(pf - 1) == 0);
    end
  endtask

  initial begin
    logic [IN_W-1:0] pat;
    rst = 1'b1; flush = 1'b0; s_vld = 1'b1; m_rdy = 1'b1;
    s_data = rand_word();
    repeat (3) @(posedge clk);
    #1;
    // Directed first word: lanes 0..15 carry their own index.
    for (int k = 0; k < RATIO; k++) pat[k*OUT_W +: OUT_W] = OUT_W'(k);
    rst = 1'b0; s_data = pat; s_vld = 1'b1; m_rdy = 1'b1;
    // Back-to-back full-rate stream covering more than one line.
    run(2100, 100, 100, 0);
    // Stalls and input gaps.
    run(1500, 80, 60, 0);
    run(800, 30, 90, 0);
    // Occasional flushes.
    run(1500, 90, 80, 40);
    // Reset mid-stream with input still valid.
    @(posedge clk); #1; rst = 1'b1; s_vld = 1'b1;
    repeat (2) @(posedge clk);
    #1; rst = 1'b0;
    run(600, 100, 70, 0);
    // Drain.
    s_vld = 1'b0; m_rdy = 1'b1; flush = 1'b0;
    repeat (40) @(posedge clk);
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
